// File: rtl/registro_univ.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : registro_univ                                              |
// | Description : Universal shift register (shift / rotate / parallel load / |
// |               hold) with a counted-burst engine for shift and rotate.    |
// |               Optional arithmetic right shift is enabled by defining     |
// |               the macro REGISTRO_ARITH_EN, which adds the ARITH input.   |
// | Ports       : CLK    rising-edge clock                                   |
// |               RST_N  asynchronous active-low reset                       |
// |               ENB    global enable, low freezes all state                |
// |               DIR    0 = toward MSB (left), 1 = toward LSB (right)       |
// |               S_IN   serial input bit for shift mode                     |
// |               MODO   00 shift, 01 rotate, 10 load, 11 hold               |
// |               D      parallel load data                                  |
// |               START  request a burst of CNT shift/rotate steps           |
// |               CNT    burst step count (values above WIDTH clamp)         |
// |               ARITH  (macro only) sign-extend on right shift             |
// |               Q      register contents                                   |
// |               S_OUT  last bit shifted/rotated out                        |
// |               BUSY   burst in progress                                   |
// |               DONE   one-cycle burst completion pulse                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module registro_univ #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             ENB,
   input  logic             DIR,
   input  logic             S_IN,
   input  logic [1:0]       MODO,
   input  logic [WIDTH-1:0] D,
   input  logic             START,
   input  logic [CW-1:0]    CNT,
`ifdef REGISTRO_ARITH_EN
   input  logic             ARITH,
`endif
   output logic [WIDTH-1:0] Q,
   output logic             S_OUT,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [1:0]    c_IDLE   = 2'd0;
   localparam logic [1:0]    c_BURST  = 2'd1;
   localparam logic [1:0]    c_FIN    = 2'd2;
   localparam logic [CW-1:0] c_MAXCNT = CW'(WIDTH);
   localparam logic [CW-1:0] c_ONE    = CW'(1);

   logic [1:0]       r_state,  w_nextState;
   logic [WIDTH-1:0] r_q,      w_nextQ;
   logic             r_sOut,   w_nextSOut;
   logic [CW-1:0]    r_count,  w_nextCount;
   logic             r_rotate, w_nextRotate;
   logic             r_dir,    w_nextDir;
   logic             r_arith,  w_nextArith;

   logic [CW-1:0]    w_cntClamp;
   logic             w_startBurst;
   logic             w_stepRotate;
   logic             w_stepDir;
   logic             w_stepArith;
   logic             w_arithLive;
   logic             w_insMsb;
   logic [WIDTH-1:0] w_stepQ;
   logic             w_stepOut;

`ifdef REGISTRO_ARITH_EN
   assign w_arithLive = ARITH;
`else
   assign w_arithLive = 1'b0;
`endif

   assign w_cntClamp   = (CNT > c_MAXCNT) ? c_MAXCNT : CNT;
   // Only shift and rotate can start a burst; load/hold with START run normally.
   assign w_startBurst = START & ~MODO[1];

   // During a burst the step follows the controls latched at START.
   assign w_stepRotate = (r_state == c_BURST) ? r_rotate : MODO[0];
   assign w_stepDir    = (r_state == c_BURST) ? r_dir    : DIR;
   assign w_stepArith  = (r_state == c_BURST) ? r_arith  : w_arithLive;

   // One shift/rotate step of the current register value.
   always_comb begin
      w_insMsb  = S_IN;
      w_stepQ   = r_q;
      w_stepOut = 1'b0;
      if (!w_stepDir) begin
         w_stepOut = r_q[WIDTH-1];
         w_stepQ   = {r_q[WIDTH-2:0], (w_stepRotate ? r_q[WIDTH-1] : S_IN)};
      end else begin
         w_stepOut = r_q[0];
         if (w_stepRotate) begin
            w_insMsb = r_q[0];
         end else if (w_stepArith) begin
            w_insMsb = r_q[WIDTH-1];
         end else begin
            w_insMsb = S_IN;
         end
         w_stepQ = {w_insMsb, r_q[WIDTH-1:1]};
      end
   end

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= c_IDLE;
         r_q      <= '0;
         r_sOut   <= 1'b0;
         r_count  <= '0;
         r_rotate <= 1'b0;
         r_dir    <= 1'b0;
         r_arith  <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_q      <= w_nextQ;
         r_sOut   <= w_nextSOut;
         r_count  <= w_nextCount;
         r_rotate <= w_nextRotate;
         r_dir    <= w_nextDir;
         r_arith  <= w_nextArith;
      end
   end

   // Next-state logic; r_count holds the steps still to do after this edge.
   always_comb begin
      w_nextState  = r_state;
      w_nextQ      = r_q;
      w_nextSOut   = r_sOut;
      w_nextCount  = r_count;
      w_nextRotate = r_rotate;
      w_nextDir    = r_dir;
      w_nextArith  = r_arith;
      if (ENB) begin
         case (r_state)
            c_IDLE: begin
               if (w_startBurst) begin
                  w_nextRotate = MODO[0];
                  w_nextDir    = DIR;
                  w_nextArith  = w_arithLive;
                  if (w_cntClamp != '0) begin
                     w_nextQ     = w_stepQ;
                     w_nextSOut  = w_stepOut;
                     w_nextCount = w_cntClamp - c_ONE;
                  end else begin
                     w_nextCount = '0;
                  end
                  w_nextState = (w_cntClamp > c_ONE) ? c_BURST : c_FIN;
               end else begin
                  case (MODO)
                     2'b00, 2'b01: begin
                        w_nextQ    = w_stepQ;
                        w_nextSOut = w_stepOut;
                     end
                     2'b10:   w_nextQ = D;
                     default: w_nextQ = r_q;
                  endcase
               end
            end
            c_BURST: begin
               w_nextQ     = w_stepQ;
               w_nextSOut  = w_stepOut;
               w_nextCount = r_count - c_ONE;
               if (r_count <= c_ONE) begin
                  w_nextCount = '0;
                  w_nextState = c_FIN;
               end
            end
            c_FIN:   w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
         endcase
      end
   end

   // Outputs; BUSY also covers the accepting cycle of a multi-step burst.
   always_comb begin
      Q     = r_q;
      S_OUT = r_sOut;
      DONE  = (r_state == c_FIN);
      BUSY  = (r_state == c_BURST) |
              (RST_N & ENB & (r_state == c_IDLE) & w_startBurst & (w_cntClamp > c_ONE));
   end

endmodule
`default_nettype wire

// File: doc/registro_univ.md
REGISTRO_UNIV -- requirements
Module: registro_univ

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter CW, default $clog2(WIDTH+1), width of the burst-count input.
REQ-003 The block SHALL have one clock and asynchronous active-low reset: CLK input 1, rising-edge clock; RST_N input 1, asynchronous active-low reset.
REQ-004 ENB  input  1  global enable; low freezes all state (Q, S_OUT, FSM, counter).
REQ-005 DIR  input  1  0 = shift/rotate left (toward MSB), 1 = right (toward LSB).
REQ-006 S_IN  input  1  serial input bit for shift mode.
REQ-007 MODO  input  2  00 shift, 01 rotate, 10 parallel load, 11 hold.
REQ-008 D  input  WIDTH  parallel load data.
REQ-009 START  input  1  request a counted burst of CNT shift/rotate steps.
REQ-010 CNT  input  CW  burst step count, 0..WIDTH.
REQ-011 Q  output  WIDTH  register contents.
REQ-012 S_OUT  output  1  registered copy of the last bit shifted/rotated out.
REQ-013 BUSY  output  1  high while a burst is executing.
REQ-014 DONE  output  1  one-cycle pulse when a burst completes.

Function
REQ-015 FSM states IDLE, BURST, FIN; all transitions only on rising CLK with ENB=1.
REQ-016 IDLE, START=0: per-cycle op per MODO; 00 shift inserts S_IN at LSB (DIR=0) or MSB (DIR=1); 01 rotate feeds exiting bit back; 10 Q<=D; 11 Q holds.
REQ-017 Each shift/rotate step SHALL load S_OUT with the exiting bit (Q[WIDTH-1] for DIR=0, Q[0] for DIR=1); load/hold leave S_OUT unchanged.
REQ-018 IDLE, START=1, MODO in {00,01}: latch MODO, DIR, CNT; perform first step same edge if CNT>0; go BURST if CNT>1, else FIN.
REQ-019 START=1 with MODO in {10,11} SHALL be ignored as a burst; the MODO operation executes as in REQ-016.
REQ-020 BURST: one step per enabled cycle using latched MODO/DIR; S_IN sampled live each step; live MODO, DIR, START, CNT, D ignored.
REQ-021 Remaining-step counter decrements per step; after the final step go FIN.
REQ-022 CNT=0 with START SHALL perform no step and go FIN (DONE pulse with Q unchanged).
REQ-023 CNT>WIDTH SHALL be clamped to WIDTH.
REQ-024 BUSY=1 in BURST and on the edge entering it; BUSY=0 in IDLE and FIN.
REQ-025 FIN: DONE=1 for exactly one enabled cycle, Q holds, return IDLE; START in FIN ignored.
REQ-026 ENB=0 mid-burst pauses; resumes at the same count when ENB returns; DONE stays high while paused in FIN.

Reset
REQ-027 RST_N=0 SHALL immediately force Q=0, S_OUT=0, BUSY=0, DONE=0, counter=0, FSM=IDLE, regardless of CLK.
REQ-028 Reset mid-burst SHALL abort it with no DONE pulse; operation resumes on the first rising CLK after RST_N deasserts.

Configuration
REQ-029 Macro REGISTRO_ARITH_EN: when defined, add input ARITH (1 bit); with ARITH=1, MODO=00, DIR=1 the inserted MSB SHALL be Q[WIDTH-1] (sign-extend) instead of S_IN, also in bursts (ARITH latched at START).
REQ-030 Without REGISTRO_ARITH_EN there SHALL be no ARITH port and shift always inserts S_IN.

Verification (WIDTH=8)
REQ-031 Reset: drive RST_N=0 between edges -> Q=0x00, S_OUT=0, BUSY=0, DONE=0 immediately.
REQ-032 Load D=0xA5, MODO=10 -> Q=0xA5; then MODO=01, DIR=0, 1 cycle -> Q=0x4B, S_OUT=1.
REQ-033 Q=0x81, START with MODO=00, DIR=1, CNT=3, S_IN=0 -> Q=0x10 after 3 cycles, BUSY high 3 cycles, DONE pulse on 4th, S_OUT=0.
REQ-034 Burst CNT=5 with ENB low 2 cycles mid-burst -> exactly 5 steps total, DONE delayed by 2 cycles.
REQ-035 START with CNT=0 -> Q unchanged, BUSY never high, DONE pulse next cycle; CNT=12 rotate of 0x3C -> 8 steps, Q=0x3C.
REQ-036 With REGISTRO_ARITH_EN, Q=0x80, ARITH=1, burst right shift CNT=3 -> Q=0xF0; RST_N pulse mid-burst -> Q=0x00, no DONE.
